axi_reg_slice: RTL and testbench

Full-throughput AXI4 register slice that breaks every combinational path between an upstream AXI master and the `axi_channel` slave adapter stage. It inserts one two-entry skid buffer on each of the five channels (AW, W, B, AR, R), so both the payload/valid path and the ready path are registered in each direction. Transaction content, ordering and ID handling are unchanged; only one cycle of latency is added per channel.

---
 rtl/axi_reg_slice.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_axi_reg_slice.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one two-entry skid buffer per channel, 1 cycle latency, full throughput.
// Readies depend only on buffer state, so a stalled consumer is seen upstream one cycle later.

module axi_reg_slice_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_hs;
  logic             out_hs;
  logic             load_main;
  logic             load_skid;
  logic             move_skid;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (in_hs) state_nxt = FULL1;
      end
      FULL1: begin
        if (in_hs && !out_hs) begin
          state_nxt = FULL2;
        end else if (!in_hs && out_hs) begin
          state_nxt = EMPTY;
        end
      end
      FULL2: begin
        if (out_hs) state_nxt = FULL1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Ready is held low through reset so nothing is accepted into a buffer being cleared.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = !rst;
      end
      FULL1: begin
        in_ready  = !rst;
        out_valid = 1'b1;
      end
      FULL2: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign load_main = in_hs && ((state == EMPTY) || ((state == FULL1) && out_hs));
  assign load_skid = in_hs && (state == FULL1) && !out_hs;
  assign move_skid = out_hs && (state == FULL2);

  always_ff @(posedge clk) begin
    if (load_main) begin
      main_q <= in_data;
    end else if (move_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule

module axi_reg_slice #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    incoming_aw_valid,
  output logic                    incoming_aw_ready,
  input  logic [ID_WIDTH-1:0]     incoming_aw_id,
  input  logic [ADDR_WIDTH-1:0]   incoming_aw_addr,
  input  logic [7:0]              incoming_aw_len,
  input  logic [2:0]              incoming_aw_size,
  input  logic [1:0]              incoming_aw_burst,
  input  logic                    incoming_aw_lock,
  input  logic [3:0]              incoming_aw_cache,
  input  logic [2:0]              incoming_aw_prot,
  input  logic [3:0]              incoming_aw_region,
  input  logic [3:0]              incoming_aw_qos,
  input  logic [USER_WIDTH-1:0]   incoming_aw_user,

  input  logic                    incoming_w_valid,
  output logic                    incoming_w_ready,
  input  logic [DATA_WIDTH-1:0]   incoming_w_data,
  input  logic [DATA_WIDTH/8-1:0] incoming_w_strb,
  input  logic                    incoming_w_last,
  input  logic [USER_WIDTH-1:0]   incoming_w_user,

  output logic                    incoming_b_valid,
  input  logic                    incoming_b_ready,
  output logic [ID_WIDTH-1:0]     incoming_b_id,
  output logic [1:0]              incoming_b_resp,
  output logic [USER_WIDTH-1:0]   incoming_b_user,

  input  logic                    incoming_ar_valid,
  output logic                    incoming_ar_ready,
  input  logic [ID_WIDTH-1:0]     incoming_ar_id,
  input  logic [ADDR_WIDTH-1:0]   incoming_ar_addr,
  input  logic [7:0]              incoming_ar_len,
  input  logic [2:0]              incoming_ar_size,
  input  logic [1:0]              incoming_ar_burst,
  input  logic                    incoming_ar_lock,
  input  logic [3:0]              incoming_ar_cache,
  input  logic [2:0]              incoming_ar_prot,
  input  logic [3:0]              incoming_ar_region,
  input  logic [3:0]              incoming_ar_qos,
  input  logic [USER_WIDTH-1:0]   incoming_ar_user,

  output logic                    incoming_r_valid,
  input  logic                    incoming_r_ready,
  output logic [ID_WIDTH-1:0]     incoming_r_id,
  output logic [DATA_WIDTH-1:0]   incoming_r_data,
  output logic [1:0]              incoming_r_resp,
  output logic                    incoming_r_last,
  output logic [USER_WIDTH-1:0]   incoming_r_user,

  output logic                    outgoing_aw_valid,
  input  logic                    outgoing_aw_ready,
  output logic [ID_WIDTH-1:0]     outgoing_aw_id,
  output logic [ADDR_WIDTH-1:0]   outgoing_aw_addr,
  output logic [7:0]              outgoing_aw_len,
  output logic [2:0]              outgoing_aw_size,
  output logic [1:0]              outgoing_aw_burst,
  output logic                    outgoing_aw_lock,
  output logic [3:0]              outgoing_aw_cache,
  output logic [2:0]              outgoing_aw_prot,
  output logic [3:0]              outgoing_aw_region,
  output logic [3:0]              outgoing_aw_qos,
  output logic [USER_WIDTH-1:0]   outgoing_aw_user,

  output logic                    outgoing_w_valid,
  input  logic                    outgoing_w_ready,
  output logic [DATA_WIDTH-1:0]   outgoing_w_data,
  output logic [DATA_WIDTH/8-1:0] outgoing_w_strb,
  output logic                    outgoing_w_last,
  output logic [USER_WIDTH-1:0]   outgoing_w_user,

  input  logic                    outgoing_b_valid,
  output logic                    outgoing_b_ready,
  input  logic [ID_WIDTH-1:0]     outgoing_b_id,
  input  logic [1:0]              outgoing_b_resp,
  input  logic [USER_WIDTH-1:0]   outgoing_b_user,

  output logic                    outgoing_ar_valid,
  input  logic                    outgoing_ar_ready,
  output logic [ID_WIDTH-1:0]     outgoing_ar_id,
  output logic [ADDR_WIDTH-1:0]   outgoing_ar_addr,
  output logic [7:0]              outgoing_ar_len,
  output logic [2:0]              outgoing_ar_size,
  output logic [1:0]              outgoing_ar_burst,
  output logic                    outgoing_ar_lock,
  output logic [3:0]              outgoing_ar_cache,
  output logic [2:0]              outgoing_ar_prot,
  output logic [3:0]              outgoing_ar_region,
  output logic [3:0]              outgoing_ar_qos,
  output logic [USER_WIDTH-1:0]   outgoing_ar_user,

  input  logic                    outgoing_r_valid,
  output logic                    outgoing_r_ready,
  input  logic [ID_WIDTH-1:0]     outgoing_r_id,
  input  logic [DATA_WIDTH-1:0]   outgoing_r_data,
  input  logic [1:0]              outgoing_r_resp,
  input  logic                    outgoing_r_last,
  input  logic [USER_WIDTH-1:0]   outgoing_r_user
);
  localparam int AX_W = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 29;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;

  axi_reg_slice_skid #(.WIDTH(AX_W)) u_aw (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (incoming_aw_valid),
    .in_ready  (incoming_aw_ready),
    .in_data   ({incoming_aw_id, incoming_aw_addr, incoming_aw_len, incoming_aw_size,
                 incoming_aw_burst, incoming_aw_lock, incoming_aw_cache, incoming_aw_prot,
                 incoming_aw_region, incoming_aw_qos, incoming_aw_user}),
    .out_valid (outgoing_aw_valid),
    .out_ready (outgoing_aw_ready),
    .out_data  ({outgoing_aw_id, outgoing_aw_addr, outgoing_aw_len, outgoing_aw_size,
                 outgoing_aw_burst, outgoing_aw_lock, outgoing_aw_cache, outgoing_aw_prot,
                 outgoing_aw_region, outgoing_aw_qos, outgoing_aw_user})
  );

  axi_reg_slice_skid #(.WIDTH(W_W)) u_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (incoming_w_valid),
    .in_ready  (incoming_w_ready),
    .in_data   ({incoming_w_data, incoming_w_strb, incoming_w_last, incoming_w_user}),
    .out_valid (outgoing_w_valid),
    .out_ready (outgoing_w_ready),
    .out_data  ({outgoing_w_data, outgoing_w_strb, outgoing_w_last, outgoing_w_user})
  );

  // Return channels run against the request direction: downstream feeds, upstream drains.
  axi_reg_slice_skid #(.WIDTH(B_W)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (outgoing_b_valid),
    .in_ready  (outgoing_b_ready),
    .in_data   ({outgoing_b_id, outgoing_b_resp, outgoing_b_user}),
    .out_valid (incoming_b_valid),
    .out_ready (incoming_b_ready),
    .out_data  ({incoming_b_id, incoming_b_resp, incoming_b_user})
  );

  axi_reg_slice_skid #(.WIDTH(AX_W)) u_ar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (incoming_ar_valid),
    .in_ready  (incoming_ar_ready),
    .in_data   ({incoming_ar_id, incoming_ar_addr, incoming_ar_len, incoming_ar_size,
                 incoming_ar_burst, incoming_ar_lock, incoming_ar_cache, incoming_ar_prot,
                 incoming_ar_region, incoming_ar_qos, incoming_ar_user}),
    .out_valid (outgoing_ar_valid),
    .out_ready (outgoing_ar_ready),
    .out_data  ({outgoing_ar_id, outgoing_ar_addr, outgoing_ar_len, outgoing_ar_size,
                 outgoing_ar_burst, outgoing_ar_lock, outgoing_ar_cache, outgoing_ar_prot,
                 outgoing_ar_region, outgoing_ar_qos, outgoing_ar_user})
  );

  axi_reg_slice_skid #(.WIDTH(R_W)) u_r (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (outgoing_r_valid),
    .in_ready  (outgoing_r_ready),
    .in_data   ({outgoing_r_id, outgoing_r_data, outgoing_r_resp, outgoing_r_last,
                 outgoing_r_user}),
    .out_valid (incoming_r_valid),
    .out_ready (incoming_r_ready),
    .out_data  ({incoming_r_id, incoming_r_data, incoming_r_resp, incoming_r_last,
                 incoming_r_user})
  );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: directed latency/backpressure/reset cases plus random stress,
// all channels checked in order against per-channel expected-beat queues.

module tb_axi_reg_slice;
  localparam int AW_W = 98;
  localparam int W_W  = 74;
  localparam int B_W  = 7;
  localparam int R_W  = 72;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Channel index: 0=AW 1=W 2=B 3=AR 4=R; src = producer side, dst = consumer side.
  logic         src_valid [5];
  logic         src_ready [5];
  logic [127:0] src_pl    [5];
  logic         dst_valid [5];
  logic         dst_ready [5];
  logic [127:0] dst_pl    [5];
  logic         src_hs    [5];
  logic [127:0] ch_mask   [5];
  logic [127:0] sb        [5][$];
  logic [127:0] exp_v;
  logic         rdy_save  [5];
  string        ch_name   [5] = '{"aw", "w", "b", "ar", "r"};
  int           n_tests = 0;
  int           n_fail  = 0;

  logic        incoming_aw_valid, incoming_aw_ready, incoming_aw_lock;
  logic [3:0]  incoming_aw_id, incoming_aw_cache, incoming_aw_region, incoming_aw_qos;
  logic [63:0] incoming_aw_addr;
  logic [7:0]  incoming_aw_len;
  logic [2:0]  incoming_aw_size, incoming_aw_prot;
  logic [1:0]  incoming_aw_burst;
  logic [0:0]  incoming_aw_user;
  logic        incoming_w_valid, incoming_w_ready, incoming_w_last;
  logic [63:0] incoming_w_data;
  logic [7:0]  incoming_w_strb;
  logic [0:0]  incoming_w_user;
  logic        incoming_b_valid, incoming_b_ready;
  logic [3:0]  incoming_b_id;
  logic [1:0]  incoming_b_resp;
  logic [0:0]  incoming_b_user;
  logic        incoming_ar_valid, incoming_ar_ready, incoming_ar_lock;
  logic [3:0]  incoming_ar_id, incoming_ar_cache, incoming_ar_region, incoming_ar_qos;
  logic [63:0] incoming_ar_addr;
  logic [7:0]  incoming_ar_len;
  logic [2:0]  incoming_ar_size, incoming_ar_prot;
  logic [1:0]  incoming_ar_burst;
  logic [0:0]  incoming_ar_user;
  logic        incoming_r_valid, incoming_r_ready, incoming_r_last;
  logic [3:0]  incoming_r_id;
  logic [63:0] incoming_r_data;
  logic [1:0]  incoming_r_resp;
  logic [0:0]  incoming_r_user;
  logic        outgoing_aw_valid, outgoing_aw_ready, outgoing_aw_lock;
  logic [3:0]  outgoing_aw_id, outgoing_aw_cache, outgoing_aw_region, outgoing_aw_qos;
  logic [63:0] outgoing_aw_addr;
  logic [7:0]  outgoing_aw_len;
  logic [2:0]  outgoing_aw_size, outgoing_aw_prot;
  logic [1:0]  outgoing_aw_burst;
  logic [0:0]  outgoing_aw_user;
  logic        outgoing_w_valid, outgoing_w_ready, outgoing_w_last;
  logic [63:0] outgoing_w_data;
  logic [7:0]  outgoing_w_strb;
  logic [0:0]  outgoing_w_user;
  logic        outgoing_b_valid, outgoing_b_ready;
  logic [3:0]  outgoing_b_id;
  logic [1:0]  outgoing_b_resp;
  logic [0:0]  outgoing_b_user;
  logic        outgoing_ar_valid, outgoing_ar_ready, outgoing_ar_lock;
  logic [3:0]  outgoing_ar_id, outgoing_ar_cache, outgoing_ar_region, outgoing_ar_qos;
  logic [63:0] outgoing_ar_addr;
  logic [7:0]  outgoing_ar_len;
  logic [2:0]  outgoing_ar_size, outgoing_ar_prot;
  logic [1:0]  outgoing_ar_burst;
  logic [0:0]  outgoing_ar_user;
  logic        outgoing_r_valid, outgoing_r_ready, outgoing_r_last;
  logic [3:0]  outgoing_r_id;
  logic [63:0] outgoing_r_data;
  logic [1:0]  outgoing_r_resp;
  logic [0:0]  outgoing_r_user;

  assign incoming_aw_valid = src_valid[0];
  assign src_ready[0]      = incoming_aw_ready;
  assign {incoming_aw_id, incoming_aw_addr, incoming_aw_len, incoming_aw_size, incoming_aw_burst,
          incoming_aw_lock, incoming_aw_cache, incoming_aw_prot, incoming_aw_region,
          incoming_aw_qos, incoming_aw_user} = src_pl[0][AW_W-1:0];
  assign dst_valid[0]      = outgoing_aw_valid;
  assign outgoing_aw_ready = dst_ready[0];
  assign dst_pl[0] = {{(128-AW_W){1'b0}}, outgoing_aw_id, outgoing_aw_addr, outgoing_aw_len,
                      outgoing_aw_size, outgoing_aw_burst, outgoing_aw_lock, outgoing_aw_cache,
                      outgoing_aw_prot, outgoing_aw_region, outgoing_aw_qos, outgoing_aw_user};

  assign incoming_w_valid = src_valid[1];
  assign src_ready[1]     = incoming_w_ready;
  assign {incoming_w_data, incoming_w_strb, incoming_w_last, incoming_w_user} = src_pl[1][W_W-1:0];
  assign dst_valid[1]     = outgoing_w_valid;
  assign outgoing_w_ready = dst_ready[1];
  assign dst_pl[1] = {{(128-W_W){1'b0}}, outgoing_w_data, outgoing_w_strb, outgoing_w_last,
                      outgoing_w_user};

  assign outgoing_b_valid = src_valid[2];
  assign src_ready[2]     = outgoing_b_ready;
  assign {outgoing_b_id, outgoing_b_resp, outgoing_b_user} = src_pl[2][B_W-1:0];
  assign dst_valid[2]     = incoming_b_valid;
  assign incoming_b_ready = dst_ready[2];
  assign dst_pl[2] = {{(128-B_W){1'b0}}, incoming_b_id, incoming_b_resp, incoming_b_user};

  assign incoming_ar_valid = src_valid[3];
  assign src_ready[3]      = incoming_ar_ready;
  assign {incoming_ar_id, incoming_ar_addr, incoming_ar_len, incoming_ar_size, incoming_ar_burst,
          incoming_ar_lock, incoming_ar_cache, incoming_ar_prot, incoming_ar_region,
          incoming_ar_qos, incoming_ar_user} = src_pl[3][AW_W-1:0];
  assign dst_valid[3]      = outgoing_ar_valid;
  assign outgoing_ar_ready = dst_ready[3];
  assign dst_pl[3] = {{(128-AW_W){1'b0}}, outgoing_ar_id, outgoing_ar_addr, outgoing_ar_len,
                      outgoing_ar_size, outgoing_ar_burst, outgoing_ar_lock, outgoing_ar_cache,
                      outgoing_ar_prot, outgoing_ar_region, outgoing_ar_qos, outgoing_ar_user};

  assign outgoing_r_valid = src_valid[4];
  assign src_ready[4]     = outgoing_r_ready;
  assign {outgoing_r_id, outgoing_r_data, outgoing_r_resp, outgoing_r_last, outgoing_r_user} =
         src_pl[4][R_W-1:0];
  assign dst_valid[4]     = incoming_r_valid;
  assign incoming_r_ready = dst_ready[4];
  assign dst_pl[4] = {{(128-R_W){1'b0}}, incoming_r_id, incoming_r_data, incoming_r_resp,
                      incoming_r_last, incoming_r_user};

  axi_reg_slice #(.ID_WIDTH(4), .ADDR_WIDTH(64), .DATA_WIDTH(64), .USER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .incoming_aw_valid(incoming_aw_valid), .incoming_aw_ready(incoming_aw_ready),
    .incoming_aw_id(incoming_aw_id), .incoming_aw_addr(incoming_aw_addr),
    .incoming_aw_len(incoming_aw_len), .incoming_aw_size(incoming_aw_size),
    .incoming_aw_burst(incoming_aw_burst), .incoming_aw_lock(incoming_aw_lock),
    .incoming_aw_cache(incoming_aw_cache), .incoming_aw_prot(incoming_aw_prot),
    .incoming_aw_region(incoming_aw_region), .incoming_aw_qos(incoming_aw_qos),
    .incoming_aw_user(incoming_aw_user),
    .incoming_w_valid(incoming_w_valid), .incoming_w_ready(incoming_w_ready),
    .incoming_w_data(incoming_w_data), .incoming_w_strb(incoming_w_strb),
    .incoming_w_last(incoming_w_last), .incoming_w_user(incoming_w_user),
    .incoming_b_valid(incoming_b_valid), .incoming_b_ready(incoming_b_ready),
    .incoming_b_id(incoming_b_id), .incoming_b_resp(incoming_b_resp),
    .incoming_b_user(incoming_b_user),
    .incoming_ar_valid(incoming_ar_valid), .incoming_ar_ready(incoming_ar_ready),
    .incoming_ar_id(incoming_ar_id), .incoming_ar_addr(incoming_ar_addr),
    .incoming_ar_len(incoming_ar_len), .incoming_ar_size(incoming_ar_size),
    .incoming_ar_burst(incoming_ar_burst), .incoming_ar_lock(incoming_ar_lock),
    .incoming_ar_cache(incoming_ar_cache), .incoming_ar_prot(incoming_ar_prot),
    .incoming_ar_region(incoming_ar_region), .incoming_ar_qos(incoming_ar_qos),
    .incoming_ar_user(incoming_ar_user),
    .incoming_r_valid(incoming_r_valid), .incoming_r_ready(incoming_r_ready),
    .incoming_r_id(incoming_r_id), .incoming_r_data(incoming_r_data),
    .incoming_r_resp(incoming_r_resp), .incoming_r_last(incoming_r_last),
    .incoming_r_user(incoming_r_user),
    .outgoing_aw_valid(outgoing_aw_valid), .outgoing_aw_ready(outgoing_aw_ready),
    .outgoing_aw_id(outgoing_aw_id), .outgoing_aw_addr(outgoing_aw_addr),
    .outgoing_aw_len(outgoing_aw_len), .outgoing_aw_size(outgoing_aw_size),
    .outgoing_aw_burst(outgoing_aw_burst), .outgoing_aw_lock(outgoing_aw_lock),
    .outgoing_aw_cache(outgoing_aw_cache), .outgoing_aw_prot(outgoing_aw_prot),
    .outgoing_aw_region(outgoing_aw_region), .outgoing_aw_qos(outgoing_aw_qos),
    .outgoing_aw_user(outgoing_aw_user),
    .outgoing_w_valid(outgoing_w_valid), .outgoing_w_ready(outgoing_w_ready),
    .outgoing_w_data(outgoing_w_data), .outgoing_w_strb(outgoing_w_strb),
    .outgoing_w_last(outgoing_w_last), .outgoing_w_user(outgoing_w_user),
    .outgoing_b_valid(outgoing_b_valid), .outgoing_b_ready(outgoing_b_ready),
    .outgoing_b_id(outgoing_b_id), .outgoing_b_resp(outgoing_b_resp),
    .outgoing_b_user(outgoing_b_user),
    .outgoing_ar_valid(outgoing_ar_valid), .outgoing_ar_ready(outgoing_ar_ready),
    .outgoing_ar_id(outgoing_ar_id), .outgoing_ar_addr(outgoing_ar_addr),
    .outgoing_ar_len(outgoing_ar_len), .outgoing_ar_size(outgoing_ar_size),
    .outgoing_ar_burst(outgoing_ar_burst), .outgoing_ar_lock(outgoing_ar_lock),
    .outgoing_ar_cache(outgoing_ar_cache), .outgoing_ar_prot(outgoing_ar_prot),
    .outgoing_ar_region(outgoing_ar_region), .outgoing_ar_qos(outgoing_ar_qos),
    .outgoing_ar_user(outgoing_ar_user),
    .outgoing_r_valid(outgoing_r_valid), .outgoing_r_ready(outgoing_r_ready),
    .outgoing_r_id(outgoing_r_id), .outgoing_r_data(outgoing_r_data),
    .outgoing_r_resp(outgoing_r_resp), .outgoing_r_last(outgoing_r_last),
    .outgoing_r_user(outgoing_r_user)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack_ax(input logic [3:0] id, input logic [63:0] addr,
                                           input logic [7:0] len);
    logic [127:0] r;
    r = '0;
    r[AW_W-1:0] = {id, addr, len, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
    return r;
  endfunction

  function automatic logic [127:0] pack_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    logic [127:0] r;
    r = '0;
    r[W_W-1:0] = {d, s, l, 1'b0};
    return r;
  endfunction

  function automatic logic [127:0] pack_b(input logic [3:0] id, input logic [1:0] resp);
    logic [127:0] r;
    r = '0;
    r[B_W-1:0] = {id, resp, 1'b0};
    return r;
  endfunction

  function automatic logic [127:0] pack_r(input logic [3:0] id, input logic [63:0] d, input logic l);
    logic [127:0] r;
    r = '0;
    r[R_W-1:0] = {id, d, 2'b00, l, 1'b0};
    return r;
  endfunction

  // Handshakes are judged at the falling edge, where the inputs for the next rising edge are final.
  always @(negedge clk) begin
    for (int c = 0; c < 5; c++) begin
      if (rst) begin
        sb[c].delete();
        src_hs[c] = 1'b0;
      end else begin
        if (dst_valid[c] && dst_ready[c]) begin
          if (sb[c].size() == 0) begin
            check({ch_name[c], "_spurious_beat"}, 128'd1, 128'd0);
          end else begin
            exp_v = sb[c].pop_front();
            check({ch_name[c], "_beat"}, dst_pl[c], exp_v);
          end
        end
        src_hs[c] = src_valid[c] && src_ready[c];
        if (src_hs[c]) sb[c].push_back(src_pl[c] & ch_mask[c]);
      end
    end
  end

  initial begin
    int exp_out [14] = '{-1, 0, 1, 2, 2, 2, 2, 2, 3, 4, 5, 6, 7, -1};
    int nxt;
    ch_mask[0] = (128'd1 << AW_W) - 128'd1;
    ch_mask[1] = (128'd1 << W_W) - 128'd1;
    ch_mask[2] = (128'd1 << B_W) - 128'd1;
    ch_mask[3] = (128'd1 << AW_W) - 128'd1;
    ch_mask[4] = (128'd1 << R_W) - 128'd1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      src_valid[c] = 1'b0;
      dst_ready[c] = 1'b1;
      src_pl[c]    = '0;
      src_hs[c]    = 1'b0;
    end
    src_valid[0] = 1'b1;
    src_pl[0]    = pack_ax(4'd3, 64'h1000, 8'd0);
    src_valid[1] = 1'b1;
    src_pl[1]    = pack_w(64'hDEADBEEF, 8'hFF, 1'b1);

    // Reset: valid held on AW, nothing may be accepted or presented.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_aw_ready", src_ready[0], 0);
      for (int c = 0; c < 5; c++) check({ch_name[c], "_rst_valid"}, dst_valid[c], 0);
    end
    rst = 1'b0;
    #1;
    check("rel_aw_ready", src_ready[0], 1);
    check("rel_w_ready", src_ready[1], 1);
    check("rel_aw_valid", dst_valid[0], 0);

    // Single write: AW+W accepted at this edge, visible right after it.
    tick();
    src_valid[0] = 1'b0;
    src_valid[1] = 1'b0;
    check("wr_aw_valid", dst_valid[0], 1);
    check("wr_aw_fields", dst_pl[0], pack_ax(4'd3, 64'h1000, 8'd0));
    check("wr_w_valid", dst_valid[1], 1);
    check("wr_w_fields", dst_pl[1], pack_w(64'hDEADBEEF, 8'hFF, 1'b1));
    src_valid[2] = 1'b1;
    src_pl[2]    = pack_b(4'd3, 2'b00);
    tick();
    src_valid[2] = 1'b0;
    check("wr_b_valid", dst_valid[2], 1);
    check("wr_b_fields", dst_pl[2], pack_b(4'd3, 2'b00));
    check("wr_aw_drained", dst_valid[0], 0);
    tick();
    check("wr_b_drained", dst_valid[2], 0);

    // Streaming read: one AR, then 16 back-to-back R beats.
    src_valid[3] = 1'b1;
    src_pl[3]    = pack_ax(4'd5, 64'h2000, 8'd15);
    tick();
    src_valid[3] = 1'b0;
    check("rd_ar_valid", dst_valid[3], 1);
    check("rd_ar_fields", dst_pl[3], pack_ax(4'd5, 64'h2000, 8'd15));
    src_valid[4] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_pl[4] = pack_r(4'd5, 64'(i), i == 15);
      #1;
      check("rd_r_in_ready", src_ready[4], 1);
      tick();
      check("rd_r_valid", dst_valid[4], 1);
      check("rd_r_beat", dst_pl[4], pack_r(4'd5, 64'(i), i == 15));
    end
    src_valid[4] = 1'b0;
    tick();
    check("rd_r_end", dst_valid[4], 0);

    // Backpressure: W beats 0..7 with the consumer stalled in cycles 3..6.
    nxt = 0;
    for (int c = 0; c < 14; c++) begin
      dst_ready[1] = !(c >= 3 && c <= 6);
      src_valid[1] = (nxt < 8);
      src_pl[1]    = pack_w(64'(nxt), 8'hFF, nxt == 7);
      #1;
      check("bp_in_ready", src_ready[1], (c >= 4 && c <= 7) ? 0 : 1);
      check("bp_out_valid", dst_valid[1], (exp_out[c] >= 0) ? 1 : 0);
      if (exp_out[c] >= 0)
        check("bp_out_data", dst_pl[1], pack_w(64'(exp_out[c]), 8'hFF, exp_out[c] == 7));
      if (src_valid[1] && src_ready[1]) nxt++;
      tick();
    end
    src_valid[1] = 1'b0;
    dst_ready[1] = 1'b1;

    // Reset with two R beats buffered; neither may reappear.
    dst_ready[4] = 1'b0;
    src_valid[4] = 1'b1;
    src_pl[4]    = pack_r(4'd7, 64'hA, 1'b0);
    tick();
    src_pl[4]    = pack_r(4'd7, 64'hB, 1'b1);
    tick();
    src_valid[4] = 1'b0;
    check("mr_full_ready", src_ready[4], 0);
    check("mr_full_valid", dst_valid[4], 1);
    rst = 1'b1;
    tick();
    check("mr_rst_valid", dst_valid[4], 0);
    check("mr_rst_ready", src_ready[4], 0);
    rst = 1'b0;
    dst_ready[4] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_stale", dst_valid[4], 0);
    end

    // Random stress on all channels; periodically flip consumer readies mid-cycle.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 5; c++) begin
        if (!src_valid[c] || src_hs[c]) begin
          src_valid[c] = ($urandom_range(0, 3) != 0);
          src_pl[c]    = {$urandom, $urandom, $urandom, $urandom} & ch_mask[c];
        end
        dst_ready[c] = ($urandom_range(0, 3) != 0);
      end
      if (cyc % 16 == 0) begin
        #1;
        for (int c = 0; c < 5; c++) rdy_save[c] = src_ready[c];
        for (int c = 0; c < 5; c++) dst_ready[c] = !dst_ready[c];
        #1;
        for (int c = 0; c < 5; c++) check({ch_name[c], "_ready_indep"}, src_ready[c], rdy_save[c]);
        for (int c = 0; c < 5; c++) dst_ready[c] = !dst_ready[c];
      end
      tick();
    end

    for (int c = 0; c < 5; c++) begin
      src_valid[c] = 1'b0;
      dst_ready[c] = 1'b1;
    end
    repeat (4) tick();
    for (int c = 0; c < 5; c++) check({ch_name[c], "_drained"}, sb[c].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
